// File: rtl/alarm_pkg.sv
// Shared alarm-editor types and limits. Optional blink is enabled with ALARM_EDITOR_BLINK_EN.
package alarm_pkg;

    localparam int unsigned HOUR_W   = 5;
    localparam int unsigned MIN_W    = 6;
    localparam int unsigned HOUR_MAX = 23;
    localparam int unsigned MIN_MAX  = 59;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        EDIT_HOUR = 2'd1,
        EDIT_MIN  = 2'd2
    } edit_state_e;

    typedef enum logic {
        FIELD_HOUR = 1'b0,
        FIELD_MIN  = 1'b1
    } edit_field_e;

    // Field selected while sitting in a given state; hour outside EDIT_MIN.
    function automatic edit_field_e field_of(input edit_state_e s);
        return (s == EDIT_MIN) ? FIELD_MIN : FIELD_HOUR;
    endfunction

endpackage

// File: rtl/alarm_field_counter.sv
// Modulo-(MAX+1) up/down counter with synchronous load, used for one time field.
module alarm_field_counter
    import alarm_pkg::*;
#(
    parameter int unsigned MAX       = 59,
    parameter int unsigned W         = 6,
    parameter int unsigned RESET_VAL = 0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         inc_i,
    input  logic         dec_i,
    output logic [W-1:0] value_o
);

    logic [W-1:0] value_q;
    logic [W-1:0] value_d;

    // Load wins; inc and dec together cancel.
    always_comb begin
        value_d = value_q;
        if (load_i) begin
            value_d = load_val_i;
        end else if (inc_i && !dec_i) begin
            value_d = (value_q == W'(MAX)) ? '0 : value_q + W'(1);
        end else if (dec_i && !inc_i) begin
            value_d = (value_q == '0) ? W'(MAX) : value_q - W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            value_q <= W'(RESET_VAL);
        end else begin
            value_q <= value_d;
        end
    end

    assign value_o = value_q;

endmodule

// File: rtl/alarm_time_editor.sv
// Alarm time editor: edits a working HH:MM copy and commits or discards it on mode exit.
// Define ALARM_EDITOR_BLINK_EN to blink the selected field at tick_1s.
module alarm_time_editor
    import alarm_pkg::*;
#(
    parameter int unsigned RESET_HOUR = 6,
    parameter int unsigned RESET_MIN  = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              alarm_set_mode,
    input  logic              mode_timeout,
    input  logic              btnU_pulse,
    input  logic              btnD_pulse,
    input  logic              btnL_pulse,
    input  logic              btnR_pulse,
    input  logic              tick_1s,
    output logic [HOUR_W-1:0] alarm_hour,
    output logic [MIN_W-1:0]  alarm_min,
    output logic [HOUR_W-1:0] edit_hour,
    output logic [MIN_W-1:0]  edit_min,
    output logic              edit_field,
    output logic              blink,
    output logic              activity_pulse,
    output logic              commit_pulse
);

    edit_state_e       state_q;
    edit_field_e       edit_field_q;
    logic              mode_q;
    logic [HOUR_W-1:0] alarm_hour_q;
    logic [MIN_W-1:0]  alarm_min_q;
    logic              activity_q;
    logic              commit_q;

    logic              entry_c;
    logic              exit_c;
    logic              editing_c;
    logic              up_c;
    logic              dn_c;
    logic              toggle_c;
    logic              any_btn_c;
    logic              hour_sel_c;
    logic              min_sel_c;

    // Mode edges and qualified button strobes; buttons only count while editing.
    assign entry_c    = alarm_set_mode & ~mode_q;
    assign exit_c     = ~alarm_set_mode & mode_q;
    assign editing_c  = (state_q != IDLE) & alarm_set_mode;
    assign up_c       = editing_c & btnU_pulse & ~btnD_pulse;
    assign dn_c       = editing_c & btnD_pulse & ~btnU_pulse;
    assign toggle_c   = editing_c & (btnL_pulse ^ btnR_pulse);
    assign any_btn_c  = editing_c & (btnU_pulse | btnD_pulse | btnL_pulse | btnR_pulse);
    assign hour_sel_c = (state_q == EDIT_HOUR);
    assign min_sel_c  = (state_q == EDIT_MIN);

    alarm_field_counter #(
        .MAX       (HOUR_MAX),
        .W         (HOUR_W),
        .RESET_VAL (RESET_HOUR)
    ) u_hour (
        .clk        (clk),
        .reset      (reset),
        .load_i     (entry_c),
        .load_val_i (alarm_hour_q),
        .inc_i      (up_c & hour_sel_c),
        .dec_i      (dn_c & hour_sel_c),
        .value_o    (edit_hour)
    );

    alarm_field_counter #(
        .MAX       (MIN_MAX),
        .W         (MIN_W),
        .RESET_VAL (RESET_MIN)
    ) u_min (
        .clk        (clk),
        .reset      (reset),
        .load_i     (entry_c),
        .load_val_i (alarm_min_q),
        .inc_i      (up_c & min_sel_c),
        .dec_i      (dn_c & min_sel_c),
        .value_o    (edit_min)
    );

    // Edit FSM plus committed value and handshake pulses.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            edit_field_q <= FIELD_HOUR;
            mode_q       <= 1'b0;
            alarm_hour_q <= HOUR_W'(RESET_HOUR);
            alarm_min_q  <= MIN_W'(RESET_MIN);
            activity_q   <= 1'b0;
            commit_q     <= 1'b0;
        end else begin
            mode_q     <= alarm_set_mode;
            activity_q <= any_btn_c;
            commit_q   <= 1'b0;
            if (entry_c) begin
                state_q      <= EDIT_HOUR;
                edit_field_q <= field_of(EDIT_HOUR);
            end else if (exit_c) begin
                state_q      <= IDLE;
                edit_field_q <= field_of(IDLE);
                // A timeout exit abandons the working copy.
                if ((state_q != IDLE) && !mode_timeout) begin
                    alarm_hour_q <= edit_hour;
                    alarm_min_q  <= edit_min;
                    commit_q     <= 1'b1;
                end
            end else if (toggle_c) begin
                case (state_q)
                    EDIT_HOUR: begin
                        state_q      <= EDIT_MIN;
                        edit_field_q <= field_of(EDIT_MIN);
                    end
                    EDIT_MIN: begin
                        state_q      <= EDIT_HOUR;
                        edit_field_q <= field_of(EDIT_HOUR);
                    end
                    default: begin
                        state_q      <= IDLE;
                        edit_field_q <= field_of(IDLE);
                    end
                endcase
            end
        end
    end

`ifdef ALARM_EDITOR_BLINK_EN
    logic blink_q;

    // Keep the field lit when idle or just adjusted; otherwise flash once per second.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            blink_q <= 1'b1;
        end else if (!editing_c || (btnU_pulse | btnD_pulse)) begin
            blink_q <= 1'b1;
        end else if (tick_1s) begin
            blink_q <= ~blink_q;
        end
    end

    assign blink = blink_q;
`else
    logic unused_tick;

    assign unused_tick = tick_1s;
    assign blink       = 1'b1;
`endif

    assign alarm_hour     = alarm_hour_q;
    assign alarm_min      = alarm_min_q;
    assign edit_field     = edit_field_q;
    assign activity_pulse = activity_q;
    assign commit_pulse   = commit_q;

endmodule
